cim_cmd_seq: RTL and testbench
==============================

# cim_cmd_seq

Command sequencer that sits directly upstream of the CIM array controller and drives its `op_code`, `bank_sel` and `word` inputs. It buffers host commands in a small FIFO and holds each operation on the array for a per-operation number of cycles. It also expands bank bursts into consecutive per-bank operations, inserting a mandatory one-cycle NOP turnaround between them.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: command FIFO entries; a power of 2 and ≥2.
- `MAC_CYCLES`, 4: cycles op 2'b00 (MAC) is held; ≥1.
- `RD_CYCLES`, 2: cycles op 2'b01 (read) is held; ≥1.
- `WR_CYCLES`, 3: cycles op 2'b10 (write) is held; ≥1.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  host command valid.
- `cmd_ready`  out  1  FIFO can accept a command.
- `cmd_op`  in  2  00 MAC, 01 read, 10 write, 11 illegal.
- `cmd_bank`  in  4  first bank.
- `cmd_word`  in  8  word/row address, held for the whole burst.
- `cmd_burst`  in  4  number of additional banks (0 = single bank, 15 = all 16).
- `op_code`  out  2  to the array controller; 2'b11 = NOP.
- `bank_sel`  out  4  to the array controller.
- `word`  out  8  to the array controller.
- `busy`  out  1  sequencer not in IDLE.
- `done`  out  1  one-cycle pulse when a command's last bank completes.
- `err`  out  1  one-cycle pulse when an illegal command is dropped.

## Operation
- FIFO:
  - Push on `cmd_valid & cmd_ready`. `cmd_ready = ~full`, computed from the registered count.
  - When full, no push is accepted, even if a pop happens in the same cycle.
  - Push and pop in the same cycle (not full) leaves the count unchanged.
  - Entries are stored in arrival order.
- FSM states: IDLE, ISSUE, GAP.
- IDLE, FIFO empty: stay in IDLE, `op_code`=11.
- IDLE, FIFO not empty: pop the head.
  - Op 11: drop the command, pulse `err`, stay in IDLE.
  - Otherwise: load `op_code`/`bank_sel`/`word` from the head, set `burst_left = cmd_burst`, set `cnt = CYC(op)-1`, go to ISSUE.
- ISSUE:
  - `cnt != 0`: decrement `cnt` and hold the outputs.
  - `cnt == 0`, `burst_left != 0`: `op_code`←11, `bank_sel`←`bank_sel+1` mod 16 (15 wraps to 0), decrement `burst_left`, go to GAP.
  - `cnt == 0`, `burst_left == 0`: `op_code`←11, pulse `done`, go to IDLE.
- GAP: `op_code`←saved op, reload `cnt = CYC(op)-1`, go to ISSUE. `word` is unchanged.
- `bank_sel` and `word` keep their last values while `op_code`=11.
- `busy` = 1 in ISSUE and GAP.
- All outputs are registered; there are no combinational paths from `cmd_*` to `op_code`/`bank_sel`/`word`.

## Timing
- Reset values: `op_code`=2'b11, `bank_sel`=0, `word`=0, `busy`=0, `done`=0, `err`=0, `cmd_ready`=1, FIFO empty, state IDLE.
- Reset mid-operation: everything returns to the reset values immediately; queued commands are discarded.
- Latency: a command accepted at edge E into an empty FIFO with the FSM in IDLE drives `op_code` from edge E+1.
- Hold and turnaround:
  - Each bank holds a valid `op_code` for exactly CYC(op) cycles.
  - Consecutive banks of one burst are separated by exactly 1 NOP cycle.
  - Consecutive commands are separated by ≥1 NOP cycle (the IDLE cycle).
- `done` and `err` are asserted for exactly one cycle:
  - `done` is high in the first NOP cycle after the last bank.
  - `err` is high in the cycle after the illegal entry is popped.
- Burst of N+1 banks occupies `(N+1)*CYC + N` cycles of ISSUE/GAP.
- Throughput: `cmd_ready` deasserts the cycle after the FIFO_DEPTH-th unpopped entry is accepted, and reasserts the cycle after a pop.

## Test plan
- Reset, then MAC, bank 3, word 0xA5, burst 0, accepted at E0 -> `op_code`=00, `bank_sel`=3, `word`=0xA5 for E1–E4; `op_code`=11 and `done`=1 at E5 only; `busy` high during E1–E4.
- Write, bank 14, burst 2 -> banks 14, 15, 0, each with `op_code`=10 for 3 cycles, separated by single NOP cycles (11-cycle span); one `done` at the end; `word` constant throughout.
- Push 5 commands back-to-back while the FSM is busy -> 4 accepted, `cmd_ready`=0 on the 5th; after the first pop, `cmd_ready`=1 the next cycle; commands issue in push order.
- Illegal op 11 queued between two reads -> `err` pulses once, nothing is issued for it, and both reads execute with 2-cycle holds and ≥1 NOP between them.
- Assert `rst_n`=0 during cycle 2 of a MAC with 2 commands queued -> `op_code`=11 and all other outputs at reset values immediately; after release, FIFO empty and no further issue.
- Burst 15 from bank 0 with reads -> all 16 banks 0..15 visited once, in order, with 16×2+15 = 47 cycles of ISSUE/GAP.

Source files
------------

// File: rtl/cim_cmd_seq.sv
// Command sequencer in front of the CIM array controller: buffers host commands,
// holds each op for its cycle count and expands bank bursts with NOP turnarounds.
module cim_cmd_seq #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAC_CYCLES = 4,
    parameter int RD_CYCLES  = 2,
    parameter int WR_CYCLES  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_bank,
    input  logic [7:0] cmd_word,
    input  logic [3:0] cmd_burst,
    output logic [1:0] op_code,
    output logic [3:0] bank_sel,
    output logic [7:0] word,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [1:0] OP_NOP = 2'b11;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] bank;
        logic [7:0] word;
        logic [3:0] burst;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    cmd_t          mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty, push, pop;
    cmd_t          head;

    state_t     state, state_d;
    logic [1:0] op_code_d, op_sv, op_sv_d;
    logic [3:0] bank_sel_d, burst_left, burst_left_d;
    logic [7:0] word_d, cnt, cnt_d;
    logic       done_d, err_d;

    function automatic logic [7:0] cyc_m1(input logic [1:0] op);
        case (op)
            2'b00:   cyc_m1 = 8'(MAC_CYCLES - 1);
            2'b01:   cyc_m1 = 8'(RD_CYCLES - 1);
            2'b10:   cyc_m1 = 8'(WR_CYCLES - 1);
            default: cyc_m1 = 8'd0;
        endcase
    endfunction

    // A full FIFO refuses pushes even when the FSM pops in the same cycle.
    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = ~full;
    assign push      = cmd_valid & ~full;
    assign pop       = (state == IDLE) & ~empty;
    assign head      = mem[rd_ptr];
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{op: cmd_op, bank: cmd_bank, word: cmd_word, burst: cmd_burst};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_d      = state;
        op_code_d    = op_code;
        bank_sel_d   = bank_sel;
        word_d       = word;
        op_sv_d      = op_sv;
        cnt_d        = cnt;
        burst_left_d = burst_left;
        done_d       = 1'b0;
        err_d        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    if (head.op == OP_NOP) begin
                        err_d = 1'b1;
                    end else begin
                        op_code_d    = head.op;
                        op_sv_d      = head.op;
                        bank_sel_d   = head.bank;
                        word_d       = head.word;
                        burst_left_d = head.burst;
                        cnt_d        = cyc_m1(head.op);
                        state_d      = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (cnt != 8'd0) begin
                    cnt_d = cnt - 8'd1;
                end else if (burst_left != 4'd0) begin
                    op_code_d    = OP_NOP;
                    bank_sel_d   = bank_sel + 4'd1;
                    burst_left_d = burst_left - 4'd1;
                    state_d      = GAP;
                end else begin
                    op_code_d = OP_NOP;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            GAP: begin
                op_code_d = op_sv;
                cnt_d     = cyc_m1(op_sv);
                state_d   = ISSUE;
            end
            default: begin
                op_code_d = OP_NOP;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_code    <= OP_NOP;
            op_sv      <= OP_NOP;
            bank_sel   <= '0;
            word       <= '0;
            cnt        <= '0;
            burst_left <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_d;
            op_code    <= op_code_d;
            op_sv      <= op_sv_d;
            bank_sel   <= bank_sel_d;
            word       <= word_d;
            cnt        <= cnt_d;
            burst_left <= burst_left_d;
            done       <= done_d;
            err        <= err_d;
        end
    end
endmodule

// File: tb/tb_cim_cmd_seq.sv
// Directed bench for cim_cmd_seq: inputs change and outputs are sampled on the
// falling edge; every expectation is hand-derived from the command semantics.
module tb_cim_cmd_seq;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_bank;
    logic [7:0] cmd_word;
    logic [3:0] cmd_burst;
    logic [1:0] op_code;
    logic [3:0] bank_sel;
    logic [7:0] word;
    logic       busy, done, err;

    int tests = 0;
    int fails = 0;

    cim_cmd_seq #(.FIFO_DEPTH(4), .MAC_CYCLES(4), .RD_CYCLES(2), .WR_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_bank(cmd_bank), .cmd_word(cmd_word), .cmd_burst(cmd_burst),
        .op_code(op_code), .bank_sel(bank_sel), .word(word),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] bk,
                         input logic [7:0] w, input logic [3:0] bu);
        cmd_valid = v; cmd_op = op; cmd_bank = bk; cmd_word = w; cmd_burst = bu;
    endtask

    // Starts on the first cycle the op is driven; ends on the done (NOP/IDLE) cycle.
    task automatic expect_burst(input string tag, input logic [1:0] op, input logic [3:0] b0,
                                input logic [7:0] w, input int burst, input int cyc);
        logic [3:0] b;
        b = b0;
        for (int k = 0; k <= burst; k++) begin
            for (int c = 0; c < cyc; c++) begin
                chk({tag, " op"}, op_code, op);
                chk({tag, " bank"}, bank_sel, b);
                chk({tag, " word"}, word, w);
                chk({tag, " busy"}, busy, 1'b1);
                chk({tag, " done_lo"}, done, 1'b0);
                @(negedge clk);
            end
            if (k < burst) begin
                b = b + 4'd1;
                chk({tag, " gap_op"}, op_code, 2'b11);
                chk({tag, " gap_bank"}, bank_sel, b);
                chk({tag, " gap_busy"}, busy, 1'b1);
                chk({tag, " gap_done"}, done, 1'b0);
                @(negedge clk);
            end
        end
        chk({tag, " end_op"}, op_code, 2'b11);
        chk({tag, " end_done"}, done, 1'b1);
        chk({tag, " end_busy"}, busy, 1'b0);
        chk({tag, " end_word"}, word, w);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 2'b00, 4'd0, 8'd0, 4'd0);
        repeat (2) @(negedge clk);
        chk("rst op", op_code, 2'b11);
        chk("rst bank", bank_sel, 4'd0);
        chk("rst word", word, 8'd0);
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst err", err, 1'b0);
        chk("rst ready", cmd_ready, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single MAC, bank 3, word A5
        drive(1'b1, 2'b00, 4'd3, 8'hA5, 4'd0);
        @(negedge clk);
        drive(1'b0, 2'b00, 4'd0, 8'd0, 4'd0);
        chk("mac pre_op", op_code, 2'b11);
        @(negedge clk);
        expect_burst("mac", 2'b00, 4'd3, 8'hA5, 0, 4);
        @(negedge clk);
        chk("mac done_once", done, 1'b0);

        // Write burst 2 from bank 14 wraps to bank 0
        drive(1'b1, 2'b10, 4'd14, 8'h5C, 4'd2);
        @(negedge clk);
        drive(1'b0, 2'b00, 4'd0, 8'd0, 4'd0);
        @(negedge clk);
        expect_burst("wrb", 2'b10, 4'd14, 8'h5C, 2, 3);
        @(negedge clk);

        // Read, illegal, read
        drive(1'b1, 2'b01, 4'd2, 8'h10, 4'd0);
        @(negedge clk);
        drive(1'b1, 2'b11, 4'd4, 8'hEE, 4'd0);
        @(negedge clk);
        chk("ill r1a_op", op_code, 2'b01);
        chk("ill r1a_bank", bank_sel, 4'd2);
        drive(1'b1, 2'b01, 4'd3, 8'h20, 4'd0);
        @(negedge clk);
        drive(1'b0, 2'b00, 4'd0, 8'd0, 4'd0);
        chk("ill r1b_op", op_code, 2'b01);
        @(negedge clk);
        chk("ill r1_end_op", op_code, 2'b11);
        chk("ill r1_done", done, 1'b1);
        chk("ill r1_err", err, 1'b0);
        @(negedge clk);
        chk("ill err_op", op_code, 2'b11);
        chk("ill err", err, 1'b1);
        chk("ill err_busy", busy, 1'b0);
        chk("ill err_done", done, 1'b0);
        @(negedge clk);
        chk("ill err_once", err, 1'b0);
        expect_burst("ill r2", 2'b01, 4'd3, 8'h20, 0, 2);
        @(negedge clk);
        chk("ill idle_op", op_code, 2'b11);
        chk("ill idle_err", err, 1'b0);

        // Fill the FIFO while a 9-cycle MAC burst runs
        drive(1'b1, 2'b00, 4'd1, 8'h01, 4'd1);
        @(negedge clk);
        drive(1'b1, 2'b01, 4'd5, 8'h11, 4'd0);
        @(negedge clk);
        chk("fifo a_op", op_code, 2'b00);
        chk("fifo rdy1", cmd_ready, 1'b1);
        drive(1'b1, 2'b10, 4'd6, 8'h22, 4'd0);
        @(negedge clk);
        chk("fifo rdy2", cmd_ready, 1'b1);
        drive(1'b1, 2'b00, 4'd7, 8'h33, 4'd0);
        @(negedge clk);
        chk("fifo rdy3", cmd_ready, 1'b1);
        drive(1'b1, 2'b01, 4'd8, 8'h44, 4'd1);
        @(negedge clk);
        chk("fifo full", cmd_ready, 1'b0);
        drive(1'b1, 2'b10, 4'd9, 8'h55, 4'd0);
        @(negedge clk);
        drive(1'b0, 2'b00, 4'd0, 8'd0, 4'd0);
        chk("fifo full_held", cmd_ready, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("fifo wait_rdy", cmd_ready, 1'b0);
        end
        chk("fifo a_done", done, 1'b1);
        @(negedge clk);
        chk("fifo rdy_after_pop", cmd_ready, 1'b1);
        expect_burst("fifo b", 2'b01, 4'd5, 8'h11, 0, 2);
        @(negedge clk);
        expect_burst("fifo c", 2'b10, 4'd6, 8'h22, 0, 3);
        @(negedge clk);
        expect_burst("fifo d", 2'b00, 4'd7, 8'h33, 0, 4);
        @(negedge clk);
        expect_burst("fifo e", 2'b01, 4'd8, 8'h44, 1, 2);
        repeat (2) begin
            @(negedge clk);
            chk("fifo no_f_op", op_code, 2'b11);
            chk("fifo no_f_busy", busy, 1'b0);
        end

        // Full 16-bank read burst: 16*2 + 15 = 47 busy cycles
        drive(1'b1, 2'b01, 4'd0, 8'h77, 4'd15);
        @(negedge clk);
        drive(1'b0, 2'b00, 4'd0, 8'd0, 4'd0);
        @(negedge clk);
        expect_burst("b16", 2'b01, 4'd0, 8'h77, 15, 2);
        @(negedge clk);

        // Reset during cycle 2 of a MAC with two commands queued
        drive(1'b1, 2'b00, 4'd2, 8'h99, 4'd0);
        @(negedge clk);
        drive(1'b1, 2'b01, 4'd4, 8'h66, 4'd0);
        @(negedge clk);
        drive(1'b1, 2'b10, 4'd5, 8'h67, 4'd0);
        @(negedge clk);
        drive(1'b0, 2'b00, 4'd0, 8'd0, 4'd0);
        chk("rmid op_pre", op_code, 2'b00);
        rst_n = 1'b0;
        #1;
        chk("rmid op", op_code, 2'b11);
        chk("rmid bank", bank_sel, 4'd0);
        chk("rmid word", word, 8'd0);
        chk("rmid busy", busy, 1'b0);
        chk("rmid ready", cmd_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rmid post_op", op_code, 2'b11);
            chk("rmid post_busy", busy, 1'b0);
            chk("rmid post_done", done, 1'b0);
            chk("rmid post_err", err, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
